// File: rtl/add_step_if.sv
// Handshake and data bundle for the multi-step adder.
// The master drives the request side, and the slave (add_step_seq) drives the result side.
interface add_step_if #(
   parameter int WIDTH  = 8,
   parameter int STEP_W = 8,
   parameter int CNT_W  = 4
);
   logic                start;
   logic [WIDTH-1:0]    in_data;
   logic [STEP_W-1:0]   step;
   logic [CNT_W-1:0]    repeat_n;
   logic                sat;
   logic                abort;
   logic [WIDTH-1:0]    out_data;
   logic                done;
   logic                busy;
   logic                ovf;

   modport master (
      output start, in_data, step, repeat_n, sat, abort,
      input  out_data, done, busy, ovf
   );

   modport slave (
      input  start, in_data, step, repeat_n, sat, abort,
      output out_data, done, busy, ovf
   );
endinterface

// File: rtl/add_step_seq.sv
// Multi-step adder. It latches an operand, a step and a repeat count, then adds the
// step to the accumulator once per clock until the count runs out. Overflow either
// wraps or saturates, as selected for each operation. The busy/done/abort handshake
// lets a controller sequence this block like the other step blocks.
module add_step_seq #(
   parameter int WIDTH  = 8,
   parameter int STEP_W = 8,
   parameter int CNT_W  = 4
) (
   input logic       clk,
   input logic       rst_n,
   add_step_if.slave bus
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [WIDTH-1:0]    r_acc;
   logic [WIDTH-1:0]    w_acc_nxt;
   logic [CNT_W-1:0]    r_rem;
   logic [CNT_W-1:0]    w_rem_nxt;
   logic [WIDTH-1:0]    r_step;
   logic [WIDTH-1:0]    w_step_nxt;
   logic                r_sat;
   logic                w_sat_nxt;
   logic                r_ovf_run;
   logic                w_ovf_run_nxt;
   logic [WIDTH-1:0]    r_out;
   logic [WIDTH-1:0]    w_out_nxt;
   logic                r_done;
   logic                w_done_nxt;
   logic                r_ovf;
   logic                w_ovf_nxt;

   logic [WIDTH-1:0]    w_step_ext;
   logic [WIDTH:0]      w_add;
   logic                w_carry;
   logic [WIDTH-1:0]    w_acc_add;

   // This function adds one step with a carry out. In saturate mode, a carry clamps the
   // result to all ones. The carry bit is always reported so that the sticky flag sees it.
   function automatic logic [WIDTH:0] add_step_sat(
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b,
      input logic             sat_mode
   );
      logic [WIDTH:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sat_mode && sum[WIDTH]) begin
         sum = {1'b1, {WIDTH{1'b1}}};
      end
      return sum;
   endfunction

   // Zero-extend the incoming step to the accumulator width.
   assign w_step_ext = WIDTH'(bus.step);

   // Compute one accumulation step from the latched step and the latched mode.
   assign w_add     = add_step_sat(r_acc, r_step, r_sat);
   assign w_carry   = w_add[WIDTH];
   assign w_acc_add = w_add[WIDTH-1:0];

   // Hold the state register and the datapath registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_acc     <= '0;
         r_rem     <= '0;
         r_step    <= '0;
         r_sat     <= 1'b0;
         r_ovf_run <= 1'b0;
         r_out     <= '0;
         r_done    <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_acc     <= w_acc_nxt;
         r_rem     <= w_rem_nxt;
         r_step    <= w_step_nxt;
         r_sat     <= w_sat_nxt;
         r_ovf_run <= w_ovf_run_nxt;
         r_out     <= w_out_nxt;
         r_done    <= w_done_nxt;
         r_ovf     <= w_ovf_nxt;
      end
   end

   // Compute the next state and the register updates.
   // By default everything holds its value and done drops.
   always_comb begin
      w_state_nxt   = r_state;
      w_acc_nxt     = r_acc;
      w_rem_nxt     = r_rem;
      w_step_nxt    = r_step;
      w_sat_nxt     = r_sat;
      w_ovf_run_nxt = r_ovf_run;
      w_out_nxt     = r_out;
      w_done_nxt    = 1'b0;
      w_ovf_nxt     = r_ovf;

      unique case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               if (bus.repeat_n == '0) begin
                  // A zero count passes the operand straight through in one cycle.
                  w_out_nxt  = bus.in_data;
                  w_done_nxt = 1'b1;
                  w_ovf_nxt  = 1'b0;
               end else begin
                  w_acc_nxt     = bus.in_data;
                  w_rem_nxt     = bus.repeat_n;
                  w_step_nxt    = w_step_ext;
                  w_sat_nxt     = bus.sat;
                  w_ovf_run_nxt = 1'b0;
                  w_state_nxt   = ST_RUN;
               end
            end
         end

         ST_RUN: begin
            if (bus.abort) begin
               // Abort wins even on the final addition. The visible result stays untouched.
               w_state_nxt = ST_IDLE;
            end else begin
               w_acc_nxt     = w_acc_add;
               w_ovf_run_nxt = r_ovf_run | w_carry;
               w_rem_nxt     = r_rem - CNT_W'(1);
               if (r_rem == CNT_W'(1)) begin
                  w_out_nxt   = w_acc_add;
                  w_ovf_nxt   = r_ovf_run | w_carry;
                  w_done_nxt  = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign bus.out_data = r_out;
   assign bus.done     = r_done;
   assign bus.busy     = (r_state == ST_RUN);
   assign bus.ovf      = r_ovf;

endmodule

// File: tb/tb_add_step_seq.sv
// Directed testbench for add_step_seq.
// It runs a table of single operations and then hand-written multi-cycle sequences:
// a start accepted in the done cycle, abort, start while busy, and reset mid-run.
module tb_add_step_seq;

   localparam int WIDTH  = 8;
   localparam int STEP_W = 8;
   localparam int CNT_W  = 4;

   logic clk;
   logic rst_n;

   int n_checks = 0;
   int n_pass   = 0;

   add_step_if #(.WIDTH(WIDTH), .STEP_W(STEP_W), .CNT_W(CNT_W)) bus ();

   add_step_seq #(.WIDTH(WIDTH), .STEP_W(STEP_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] din;
      logic [7:0] stp;
      logic [3:0] n;
      logic       s;
      logic [7:0] eo;
      logic       eov;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic drive_idle();
      bus.start    = 1'b0;
      bus.in_data  = '0;
      bus.step     = '0;
      bus.repeat_n = '0;
      bus.sat      = 1'b0;
      bus.abort    = 1'b0;
   endtask

   // Issue one operation. Then measure the latency to done and check the result.
   task automatic run_op(input logic [7:0] din, input logic [7:0] stp, input logic [3:0] n,
                         input logic s, input logic [7:0] eo, input logic eov, input string tag);
      int lat;
      @(negedge clk);
      bus.start = 1'b1; bus.in_data = din; bus.step = stp; bus.repeat_n = n; bus.sat = s;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk({tag, " busy_after_start"}, 32'(bus.busy), 32'(n != 4'd0));
      lat = 0;
      while (!bus.done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, " latency"}, 32'(lat), 32'(n));
      chk({tag, " out_data"}, 32'(bus.out_data), 32'(eo));
      chk({tag, " ovf"}, 32'(bus.ovf), 32'(eov));
      @(posedge clk); #1;
      chk({tag, " done_pulse_width"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      int dcount;
      vecs[0] = '{8'h10, 8'h05, 4'd3,  1'b0, 8'h1F, 1'b0};
      vecs[1] = '{8'h0A, 8'h05, 4'd0,  1'b0, 8'h0A, 1'b0};
      vecs[2] = '{8'hF0, 8'h20, 4'd2,  1'b0, 8'h30, 1'b1};
      vecs[3] = '{8'hF0, 8'h20, 4'd2,  1'b1, 8'hFF, 1'b1};
      vecs[4] = '{8'h00, 8'hFF, 4'd15, 1'b0, 8'hF1, 1'b1};
      vecs[5] = '{8'hFE, 8'h01, 4'd1,  1'b1, 8'hFF, 1'b0};
      vecs[6] = '{8'hFF, 8'h00, 4'd3,  1'b1, 8'hFF, 1'b0};
      vecs[7] = '{8'h01, 8'h01, 4'd1,  1'b0, 8'h02, 1'b0};
      vecs[8] = '{8'h80, 8'h40, 4'd1,  1'b1, 8'hC0, 1'b0};
      vecs[9] = '{8'hFE, 8'h01, 4'd2,  1'b1, 8'hFF, 1'b1};

      drive_idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset out_data", 32'(bus.out_data), 32'd0);
      chk("reset done", 32'(bus.done), 32'd0);
      chk("reset busy", 32'(bus.busy), 32'd0);
      chk("reset ovf", 32'(bus.ovf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         run_op(vecs[i].din, vecs[i].stp, vecs[i].n, vecs[i].s, vecs[i].eo, vecs[i].eov,
                $sformatf("vec%0d", i));
      end

      // Pass-through with N=0, then a start accepted in the done cycle.
      @(negedge clk);
      bus.start = 1'b1; bus.in_data = 8'h0A; bus.step = 8'h05; bus.repeat_n = 4'd0; bus.sat = 1'b0;
      @(posedge clk); #1;
      chk("b2b n0 done", 32'(bus.done), 32'd1);
      chk("b2b n0 out", 32'(bus.out_data), 32'h0A);
      chk("b2b n0 busy", 32'(bus.busy), 32'd0);
      bus.repeat_n = 4'd1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("b2b n1 busy", 32'(bus.busy), 32'd1);
      chk("b2b n1 done_low", 32'(bus.done), 32'd0);
      @(posedge clk); #1;
      chk("b2b n1 done", 32'(bus.done), 32'd1);
      chk("b2b n1 out", 32'(bus.out_data), 32'h0F);

      // Set up a known previous result (0x30, ovf=1), then abort mid-run.
      run_op(8'hF0, 8'h20, 4'd2, 1'b0, 8'h30, 1'b1, "pre_abort");
      @(negedge clk);
      bus.start = 1'b1; bus.in_data = 8'h11; bus.step = 8'h01; bus.repeat_n = 4'd5; bus.sat = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      chk("abort busy", 32'(bus.busy), 32'd0);
      dcount = 0;
      repeat (8) begin
         if (bus.done) dcount++;
         @(posedge clk); #1;
      end
      chk("abort no_done", 32'(dcount), 32'd0);
      chk("abort out_kept", 32'(bus.out_data), 32'h30);
      chk("abort ovf_kept", 32'(bus.ovf), 32'd1);

      // Abort that coincides with the final addition.
      @(negedge clk);
      bus.start = 1'b1; bus.in_data = 8'h40; bus.step = 8'h01; bus.repeat_n = 4'd2; bus.sat = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      chk("abort_final done", 32'(bus.done), 32'd0);
      chk("abort_final busy", 32'(bus.busy), 32'd0);
      chk("abort_final out_kept", 32'(bus.out_data), 32'h30);

      // A start while busy is ignored and must not be queued.
      @(negedge clk);
      bus.start = 1'b1; bus.in_data = 8'h10; bus.step = 8'h01; bus.repeat_n = 4'd4; bus.sat = 1'b0;
      @(posedge clk); #1;
      bus.in_data = 8'hAA; bus.step = 8'h33; bus.repeat_n = 4'd1; bus.sat = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      dcount = 0;
      repeat (8) begin
         if (bus.done) dcount++;
         @(posedge clk); #1;
      end
      chk("ignore_start done_count", 32'(dcount), 32'd1);
      chk("ignore_start out", 32'(bus.out_data), 32'h14);
      chk("ignore_start ovf", 32'(bus.ovf), 32'd0);

      // Reset asserted mid-run clears the outputs immediately.
      @(negedge clk);
      bus.start = 1'b1; bus.in_data = 8'h55; bus.step = 8'h03; bus.repeat_n = 4'd10; bus.sat = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid out", 32'(bus.out_data), 32'd0);
      chk("rst_mid busy", 32'(bus.busy), 32'd0);
      chk("rst_mid done", 32'(bus.done), 32'd0);
      chk("rst_mid ovf", 32'(bus.ovf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dcount = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (bus.done) dcount++;
      end
      chk("rst_mid no_done", 32'(dcount), 32'd0);
      run_op(8'h01, 8'h01, 4'd1, 1'b0, 8'h02, 1'b0, "post_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
